fp_addmul_pipe: RTL and testbench

FP_ADDMUL_PIPE -- requirements
Module: fp_addmul_pipe

---
 rtl/fp_addmul_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_addmul_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addmul_pipe.sv
// Three-stage floating-point ADD/MULT pipeline (bfloat16 by default) with a valid/ready
// handshake. Subnormals flush to zero; rounding is round-to-nearest-even.
module fp_addmul_pipe #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [2:0]            flags
);

  localparam int SIG_W = MAN_WIDTH + 1;
  localparam int W     = MAN_WIDTH + 4;   // hidden + mantissa + guard/round/sticky
  localparam int P     = 2 * SIG_W;
  localparam int XW    = EXP_WIDTH + 2;
  localparam int BIAS  = 2 ** (EXP_WIDTH - 1) - 1;

  localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = {EXP_WIDTH{1'b1}};
  localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = {EXP_WIDTH{1'b0}};
  localparam logic [MAN_WIDTH-1:0]  MAN_ZERO  = {MAN_WIDTH{1'b0}};
  localparam logic [EXP_WIDTH-1:0]  SHIFT_CAP = EXP_WIDTH'(MAN_WIDTH + 3);
  localparam logic signed [XW-1:0]  BIAS_X    = XW'(BIAS);
  localparam logic signed [XW-1:0]  EXP_MAX_X = XW'(2 ** EXP_WIDTH - 1);
  localparam logic signed [XW-1:0]  ZERO_X    = {XW{1'b0}};
  localparam logic [XW-1:0]         ONE_X     = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  function automatic logic [XW-1:0] lzc(input logic [W-1:0] v);
    logic [XW-1:0] n;
    logic          found;
    n     = {XW{1'b0}};
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + ONE_X;
      else                 found = 1'b1;
    end
    return n;
  endfunction

  logic advance_s;
  assign in_ready  = !out_valid || out_ready;
  assign advance_s = in_ready;

  logic sa_s, sb_s;
  logic [EXP_WIDTH-1:0] ea_s, eb_s;
  logic [MAN_WIDTH-1:0] fa_s, fb_s;
  logic zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
  logic [SIG_W-1:0] sig_a_s, sig_b_s;

  assign {sa_s, ea_s, fa_s} = op_a;
  assign {sb_s, eb_s, fb_s} = op_b;
  assign zero_a_s = (ea_s == EXP_ZERO);
  assign zero_b_s = (eb_s == EXP_ZERO);
  assign inf_a_s  = (ea_s == EXP_ONES) && (fa_s == MAN_ZERO);
  assign inf_b_s  = (eb_s == EXP_ONES) && (fb_s == MAN_ZERO);
  assign nan_a_s  = (ea_s == EXP_ONES) && (fa_s != MAN_ZERO);
  assign nan_b_s  = (eb_s == EXP_ONES) && (fb_s != MAN_ZERO);
  assign sig_a_s  = zero_a_s ? {SIG_W{1'b0}} : {1'b1, fa_s};
  assign sig_b_s  = zero_b_s ? {SIG_W{1'b0}} : {1'b1, fb_s};

  logic [EXP_WIDTH-1:0] e_l_s, e_s_s, diff_s;
  logic [SIG_W-1:0]     sig_l_s, sig_s_s;
  logic                 sign_l_s;
  logic [2*W-1:0]       ext_s;
  logic [W-1:0]         aligned_s, x_s, y_s;
  logic signed [XW-1:0] exp_s;
  logic                 sign_s, sub_s;

  // S1: order by magnitude and align for ADD, or add exponents for MULT
  always_comb begin
    if ({eb_s, sig_b_s[MAN_WIDTH-1:0]} > {ea_s, sig_a_s[MAN_WIDTH-1:0]}) begin
      e_l_s = eb_s; e_s_s = ea_s; sig_l_s = sig_b_s; sig_s_s = sig_a_s; sign_l_s = sb_s;
    end else begin
      e_l_s = ea_s; e_s_s = eb_s; sig_l_s = sig_a_s; sig_s_s = sig_b_s; sign_l_s = sa_s;
    end
    diff_s = e_l_s - e_s_s;
    ext_s  = {sig_s_s, 3'b000, {W{1'b0}}} >> diff_s;
    if (diff_s >= SHIFT_CAP) aligned_s = {{(W-1){1'b0}}, |sig_s_s};
    else                     aligned_s = ext_s[2*W-1:W] | {{(W-1){1'b0}}, |ext_s[W-1:0]};
    if (op == 1'b0) begin
      x_s = {sig_l_s, 3'b000}; y_s = aligned_s;
      exp_s = {2'b00, e_l_s}; sign_s = sign_l_s; sub_s = sa_s ^ sb_s;
    end else begin
      x_s = {3'b000, sig_a_s}; y_s = {3'b000, sig_b_s};
      exp_s = {2'b00, ea_s} + {2'b00, eb_s} - BIAS_X; sign_s = sa_s ^ sb_s; sub_s = 1'b0;
    end
  end

  logic                  spec_s;
  logic [DATA_WIDTH-1:0] spec_val_s;
  logic [2:0]            spec_fl_s;

  // S1: NaN/Inf/zero operands resolve here and bypass the arithmetic
  always_comb begin
    spec_s     = 1'b0;
    spec_val_s = {DATA_WIDTH{1'b0}};
    spec_fl_s  = 3'b000;
    if (nan_a_s || nan_b_s) begin
      spec_s = 1'b1; spec_val_s = QNAN; spec_fl_s = 3'b100;
    end else if (op == 1'b0) begin
      if (inf_a_s && inf_b_s && (sa_s != sb_s)) begin
        spec_s = 1'b1; spec_val_s = QNAN; spec_fl_s = 3'b100;
      end else if (inf_a_s) begin
        spec_s = 1'b1; spec_val_s = {sa_s, EXP_ONES, MAN_ZERO};
      end else if (inf_b_s) begin
        spec_s = 1'b1; spec_val_s = {sb_s, EXP_ONES, MAN_ZERO};
      end else if (zero_a_s && zero_b_s) begin
        spec_s = 1'b1; spec_val_s = {sa_s & sb_s, EXP_ZERO, MAN_ZERO};
      end else begin
        spec_s = 1'b0;
      end
    end else begin
      if ((inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
        spec_s = 1'b1; spec_val_s = QNAN; spec_fl_s = 3'b100;
      end else if (inf_a_s || inf_b_s) begin
        spec_s = 1'b1; spec_val_s = {sa_s ^ sb_s, EXP_ONES, MAN_ZERO};
      end else if (zero_a_s || zero_b_s) begin
        spec_s = 1'b1; spec_val_s = {sa_s ^ sb_s, EXP_ZERO, MAN_ZERO};
      end else begin
        spec_s = 1'b0;
      end
    end
  end

  logic                  v1_r, v2_r;
  logic                  s1_op_r, s1_sign_r, s1_sub_r, s1_spec_r;
  logic signed [XW-1:0]  s1_exp_r;
  logic [W-1:0]          s1_x_r, s1_y_r;
  logic [DATA_WIDTH-1:0] s1_spec_val_r;
  logic [2:0]            s1_spec_fl_r;
  logic                  s2_op_r, s2_sign_r, s2_spec_r;
  logic signed [XW-1:0]  s2_exp_r;
  logic [W:0]            s2_sum_r;
  logic [P-1:0]          s2_prod_r;
  logic [DATA_WIDTH-1:0] s2_spec_val_r;
  logic [2:0]            s2_spec_fl_r;

  logic [W:0]   sum_s;
  logic [P-1:0] prod_s;
  assign sum_s  = s1_sub_r ? ({1'b0, s1_x_r} - {1'b0, s1_y_r}) : ({1'b0, s1_x_r} + {1'b0, s1_y_r});
  assign prod_s = P'(s1_x_r[SIG_W-1:0]) * P'(s1_y_r[SIG_W-1:0]);

  logic [W-1:0]         norm_s;
  logic signed [XW-1:0] exp_n_s;
  logic [XW-1:0]        lz_s;
  logic                 is_zero_s;

  // S3: normalise the sum (carry or cancellation) or the product (at most one bit)
  always_comb begin
    norm_s    = {W{1'b0}};
    exp_n_s   = s2_exp_r;
    is_zero_s = 1'b0;
    lz_s      = lzc(s2_sum_r[W-1:0]);
    if (s2_op_r == 1'b0) begin
      if (s2_sum_r == {(W+1){1'b0}}) begin
        is_zero_s = 1'b1;
      end else if (s2_sum_r[W]) begin
        norm_s  = s2_sum_r[W:1] | {{(W-1){1'b0}}, s2_sum_r[0]};
        exp_n_s = s2_exp_r + ONE_X;
      end else begin
        norm_s  = s2_sum_r[W-1:0] << lz_s;
        exp_n_s = s2_exp_r - lz_s;
      end
    end else begin
      if (s2_prod_r[P-1]) begin
        norm_s  = {s2_prod_r[P-1 -: W-1], |s2_prod_r[P-W:0]};
        exp_n_s = s2_exp_r + ONE_X;
      end else begin
        norm_s  = {s2_prod_r[P-2 -: W-1], |s2_prod_r[P-W-1:0]};
      end
    end
  end

  logic                  round_up_s;
  logic [SIG_W:0]        rnd_s;
  logic signed [XW-1:0]  exp_r_s;
  logic [MAN_WIDTH-1:0]  man_s;
  logic [DATA_WIDTH-1:0] res_s;
  logic [2:0]            fl_s;

  // S3: round to nearest even, then saturate to Inf or flush to zero
  always_comb begin
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s      = {1'b0, norm_s[W-1:3]} + {{SIG_W{1'b0}}, round_up_s};
    if (rnd_s[SIG_W]) begin
      exp_r_s = exp_n_s + ONE_X; man_s = MAN_ZERO;
    end else begin
      exp_r_s = exp_n_s; man_s = rnd_s[MAN_WIDTH-1:0];
    end
    if (s2_spec_r) begin
      res_s = s2_spec_val_r; fl_s = s2_spec_fl_r;
    end else if (is_zero_s) begin
      res_s = {DATA_WIDTH{1'b0}}; fl_s = 3'b000;
    end else if (exp_r_s >= EXP_MAX_X) begin
      res_s = {s2_sign_r, EXP_ONES, MAN_ZERO}; fl_s = 3'b010;
    end else if (exp_r_s <= ZERO_X) begin
      res_s = {s2_sign_r, EXP_ZERO, MAN_ZERO}; fl_s = 3'b001;
    end else begin
      res_s = {s2_sign_r, exp_r_s[EXP_WIDTH-1:0], man_s}; fl_s = 3'b000;
    end
  end

  // Stage valid bits and registered outputs; the whole pipe freezes under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0; v2_r <= 1'b0; out_valid <= 1'b0;
      out  <= {DATA_WIDTH{1'b0}}; flags <= 3'b000;
    end else if (advance_s) begin
      v1_r <= in_valid; v2_r <= v1_r; out_valid <= v2_r;
      if (v2_r) begin
        out <= res_s; flags <= fl_s;
      end
    end
  end

  // Datapath stage registers, qualified only by the valid bits above
  always_ff @(posedge clk) begin
    if (advance_s) begin
      s1_op_r <= op; s1_sign_r <= sign_s; s1_sub_r <= sub_s; s1_exp_r <= exp_s;
      s1_x_r <= x_s; s1_y_r <= y_s;
      s1_spec_r <= spec_s; s1_spec_val_r <= spec_val_s; s1_spec_fl_r <= spec_fl_s;
      s2_op_r <= s1_op_r; s2_sign_r <= s1_sign_r; s2_exp_r <= s1_exp_r;
      s2_sum_r <= sum_s; s2_prod_r <= prod_s;
      s2_spec_r <= s1_spec_r; s2_spec_val_r <= s1_spec_val_r; s2_spec_fl_r <= s1_spec_fl_r;
    end
  end

endmodule

// File: tb/tb_fp_addmul_pipe.sv
// Directed bench for fp_addmul_pipe: table of bfloat16 vectors with hand-computed
// results, plus backpressure and mid-flight reset sequences.
module tb_fp_addmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [15:0] op_a, op_b, out;
  logic [2:0]  flags;

  int checks   = 0;
  int failures = 0;

  fp_addmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_a[4], bp_b[4], bp_exp[4];
    logic [15:0] held;
    logic        held_v, fire_in, fire_out;
    int          sent, got, extra;

    vecs[0]  = '{1'b0, 16'h3F80, 16'h4000, 16'h4040, 3'b000};
    vecs[1]  = '{1'b1, 16'h3FC0, 16'h4000, 16'h4040, 3'b000};
    vecs[2]  = '{1'b0, 16'h3F80, 16'hBF80, 16'h0000, 3'b000};
    vecs[3]  = '{1'b1, 16'h7F00, 16'h7F00, 16'h7F80, 3'b010};
    vecs[4]  = '{1'b1, 16'h0080, 16'h0080, 16'h0000, 3'b001};
    vecs[5]  = '{1'b1, 16'h7F80, 16'h0000, 16'h7FC0, 3'b100};
    vecs[6]  = '{1'b0, 16'h7F80, 16'hFF80, 16'h7FC0, 3'b100};
    vecs[7]  = '{1'b0, 16'h4000, 16'hBF80, 16'h3F80, 3'b000};
    vecs[8]  = '{1'b1, 16'h4040, 16'h4040, 16'h4110, 3'b000};
    vecs[9]  = '{1'b0, 16'h3F80, 16'h3B80, 16'h3F80, 3'b000};
    vecs[10] = '{1'b0, 16'h3F81, 16'h3B80, 16'h3F82, 3'b000};
    vecs[11] = '{1'b0, 16'h3FFF, 16'h3B80, 16'h4000, 3'b000};
    vecs[12] = '{1'b0, 16'h3FC0, 16'h3FC0, 16'h4040, 3'b000};
    vecs[13] = '{1'b0, 16'h7F7F, 16'h7F7F, 16'h7F80, 3'b010};
    vecs[14] = '{1'b0, 16'h7F80, 16'h3F80, 16'h7F80, 3'b000};
    vecs[15] = '{1'b1, 16'hFF80, 16'h4000, 16'hFF80, 3'b000};
    vecs[16] = '{1'b0, 16'h7FC1, 16'h3F80, 16'h7FC0, 3'b100};
    vecs[17] = '{1'b1, 16'h0001, 16'h4000, 16'h0000, 3'b000};
    vecs[18] = '{1'b0, 16'h3F80, 16'h0000, 16'h3F80, 3'b000};
    vecs[19] = '{1'b1, 16'hFF00, 16'h7F00, 16'hFF80, 3'b010};
    vecs[20] = '{1'b0, 16'hBF80, 16'h4000, 16'h3F80, 3'b000};

    bp_a   = '{16'h3F80, 16'h4000, 16'h3FC0, 16'h4000};
    bp_b   = '{16'h3F80, 16'h4000, 16'h3FC0, 16'hBF80};
    bp_exp = '{16'h4000, 16'h4080, 16'h4040, 16'h3F80};

    rst = 1'b1; in_valid = 1'b0; op = 1'b0; op_a = 16'h0000; op_b = 16'h0000; out_ready = 1'b1;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out", out, 0);
    check("reset flags", flags, 0);
    check("reset in_ready", in_ready, 1);
    #11;
    rst = 1'b0;

    // Vector table: one op at a time, exact 3-cycle latency
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1; op = vecs[i].op; op_a = vecs[i].a; op_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      step();
      in_valid = 1'b0;
      step();
      check($sformatf("vec%0d early valid", i), out_valid, 0);
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out", i), out, vecs[i].res);
      check($sformatf("vec%0d flags", i), flags, vecs[i].fl);
      step();
    end

    // Backpressure: four back-to-back ADDs, out_ready low for the first 6 cycles
    sent = 0; got = 0; held_v = 1'b0; held = 16'h0000;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 6);
      if (sent < 4) begin
        in_valid = 1'b1; op = 1'b0; op_a = bp_a[sent]; op_b = bp_b[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        check($sformatf("bp in_ready low c%0d", c), in_ready, 0);
        if (held_v) check($sformatf("bp out stable c%0d", c), out, held);
        held = out; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        check($sformatf("bp result %0d", got), out, bp_exp[got]);
        got++;
      end
      step();
      if (fire_in) sent++;
    end
    check("bp result count", got, 4);
    in_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      step();
    end
    check("bp no duplicates", extra, 0);

    // Reset with three operations in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; op = vecs[k].op; op_a = vecs[k].a; op_b = vecs[k].b;
      step();
    end
    in_valid = 1'b0;
    check("rst pre out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst async out_valid", out_valid, 0);
    check("rst async in_ready", in_ready, 1);
    check("rst async out", out, 0);
    check("rst async flags", flags, 0);
    #2;
    rst = 1'b0;
    in_valid = 1'b1; op = vecs[8].op; op_a = vecs[8].a; op_b = vecs[8].b;
    step();
    in_valid = 1'b0;
    check("post-rst stale 1", out_valid, 0);
    step();
    check("post-rst stale 2", out_valid, 0);
    step();
    check("post-rst first valid", out_valid, 1);
    check("post-rst first out", out, vecs[8].res);
    check("post-rst first flags", flags, vecs[8].fl);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) extra++;
    end
    check("post-rst no stale", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
